vga_timing_param: RTL and testbench

Parametrised VGA raster timing generator, the successor to the fixed 1024x768 generator. It drives the same `vga_if_no_rgb` signal set from horizontal and vertical counters. Differences from the fixed generator:
- any mode, set by porch, sync and active-size parameters;
- selectable sync polarity;
- a clock-enable input, so slower pixel rates can run from a faster system clock;
- registered line-start, frame-start and data-enable strobes for downstream draw and buffer logic.

It sits at the head of the video pipeline, feeding the background, rectangle and character draw stages.

---
 rtl/vga_timing_param.sv | 158 +++++++++++++++
 tb/tb_vga_timing_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_param
// Brief    : Parametrised VGA raster timing generator. Horizontal/vertical
//            counters with registered blanking, sync, data-enable and
//            line/frame start strobes, all aligned to the counter values
//            they describe. A clock enable lets slower pixel rates run from a
//            faster clock. Optional 16-bit frame counter is built when the
//            macro VGA_TIMING_FRAME_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_param #(
    parameter int   H_ACTIVE  = 1024,
    parameter int   H_FP      = 24,
    parameter int   H_SYNC    = 136,
    parameter int   H_BP      = 160,
    parameter int   V_ACTIVE  = 768,
    parameter int   V_FP      = 3,
    parameter int   V_SYNC    = 6,
    parameter int   V_BP      = 29,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   CNT_W     = 11
) (
    input  logic             clk65MHz,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_HB_START = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_VB_START = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject parameter sets that would give empty intervals or overflow the counters.
    generate
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
            $error("vga_timing_param: porch and sync widths must be at least 1");
        end
        if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_chk_active
            $error("vga_timing_param: active sizes must be at least 1");
        end
        if (c_H_TOTAL > 2**CNT_W || c_V_TOTAL > 2**CNT_W) begin : g_chk_width
            $error("vga_timing_param: CNT_W too small for the line or frame total");
        end
    endgenerate

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_de;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_h_wrap;
    logic [CNT_W-1:0] w_hnext;
    logic [CNT_W-1:0] w_vnext;
    logic             w_hblnk;
    logic             w_vblnk;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_de;
    logic             w_line_start;
    logic             w_frame_start;

    // Next counter values and the flags decoded from them, so every registered
    // flag lands in the same cycle as the counter value it describes.
    always_comb begin
        w_h_wrap = (r_hcount == c_H_LAST);
        w_hnext  = w_h_wrap ? '0 : r_hcount + CNT_W'(1);
        w_vnext  = r_vcount;
        if (w_h_wrap) begin
            w_vnext = (r_vcount == c_V_LAST) ? '0 : r_vcount + CNT_W'(1);
        end
        w_hblnk       = (w_hnext >= c_HB_START);
        w_vblnk       = (w_vnext >= c_VB_START);
        w_hsync       = (w_hnext >= c_HS_START && w_hnext < c_HS_END) ? HSYNC_POL : ~HSYNC_POL;
        w_vsync       = (w_vnext >= c_VS_START && w_vnext < c_VS_END) ? VSYNC_POL : ~VSYNC_POL;
        w_de          = ~w_hblnk & ~w_vblnk;
        w_line_start  = (w_hnext == '0);
        w_frame_start = w_line_start && (w_vnext == '0);
    end

    // Output registers: reset dominates, otherwise advance only when enabled.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hcount      <= w_hnext;
            r_vcount      <= w_vnext;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_hblnk       <= w_hblnk;
            r_vblnk       <= w_vblnk;
            r_de          <= w_de;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Count frames on the same edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (en && w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_param
// Brief    : Scoreboard bench for vga_timing_param. Three instances: default
//            mode, narrow lines with default vertical timing, and a tiny
//            negative-polarity mode driven with a 1-of-3 enable pattern.
//            Expected output vectors are queued per cycle from a pixel-index
//            model; a monitor pops and compares. Hand-computed boundary
//            values are checked at the end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_param;

    typedef logic [28:0] vec_t;   // {h[10:0], v[10:0], hs, vs, hb, vb, de, ls, fs}

    localparam int N_CYC     = 19400;
    localparam int A_RST_CYC = 3190;   // outputs show (500,2) just before this
    localparam int C_PH1_END = 170;    // C runs en=1 before this cycle

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;
    logic rst_c = 1'b1, en_c = 1'b0;

    logic [10:0] h_a, v_a, h_b, v_b, h_c, v_c;
    logic hs_a, vs_a, hb_a, vb_a, de_a, ls_a, fs_a;
    logic hs_b, vs_b, hb_b, vb_b, de_b, ls_b, fs_b;
    logic hs_c, vs_c, hb_c, vb_c, de_c, ls_c, fs_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b, fc_c;
`endif

    vga_timing_param u_a (
        .clk65MHz(clk), .rst(rst_a), .en(en_a), .hcount(h_a), .vcount(v_a),
        .hsync(hs_a), .vsync(vs_a), .hblnk(hb_a), .vblnk(vb_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing_param #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_b (
        .clk65MHz(clk), .rst(rst_b), .en(en_b), .hcount(h_b), .vcount(v_b),
        .hsync(hs_b), .vsync(vs_b), .hblnk(hb_b), .vblnk(vb_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    vga_timing_param #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                       .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_c (
        .clk65MHz(clk), .rst(rst_c), .en(en_c), .hcount(h_c), .vcount(v_c),
        .hsync(hs_c), .vsync(vs_c), .hblnk(hb_c), .vblnk(vb_c), .de(de_c),
        .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

    vec_t act_a, act_b, act_c;
    assign act_a = {h_a, v_a, hs_a, vs_a, hb_a, vb_a, de_a, ls_a, fs_a};
    assign act_b = {h_b, v_b, hs_b, vs_b, hb_b, vb_b, de_b, ls_b, fs_b};
    assign act_c = {h_c, v_c, hs_c, vs_c, hb_c, vb_c, de_c, ls_c, fs_c};

    vec_t qa[$], qb[$], qc[$];
    int checks = 0;
    int errors = 0;

    // Expected outputs after k enabled edges since reset, from a linear pixel index.
    function automatic vec_t model(input int k, input int ha, input int hf, input int hw, input int hbp,
                                   input int va, input int vf, input int vw, input int vbp,
                                   input bit hp, input bit vp);
        int ht, vt, p, h, v;
        bit hs, vs, hbl, vbl;
        ht = ha + hf + hw + hbp;
        vt = va + vf + vw + vbp;
        if (k == 0) return {11'd0, 11'd0, ~hp, ~vp, 5'b00000};
        p   = k % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        hbl = (h >= ha);
        vbl = (v >= va);
        hs  = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
        vs  = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
        return {11'(h), 11'(v), hs, vs, hbl, vbl, ~hbl & ~vbl, (h == 0), (p == 0)};
    endfunction

    task automatic chk_vec(input string name, input int idx, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got h=%0d v=%0d flags=%b want h=%0d v=%0d flags=%b",
                     name, idx, act[28:18], act[17:7], act[6:0], exp[28:18], exp[17:7], exp[6:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Stimulus: drive rst/en away from the active edge and queue what each DUT should show after it.
    initial begin
        int ka = 0, kb = 0, kc = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            rst_a = (cyc < 2) || (cyc == A_RST_CYC);
            en_a  = 1'b1;
            rst_b = (cyc < 2);
            en_b  = 1'b1;
            rst_c = (cyc < 2);
            en_c  = (cyc < C_PH1_END) ? 1'b1 : ((cyc % 3) == 0);
            if (rst_a) ka = 0; else if (en_a) ka++;
            if (rst_b) kb = 0; else if (en_b) kb++;
            if (rst_c) kc = 0; else if (en_c) kc++;
            qa.push_back(model(ka, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1'b1));
            qb.push_back(model(kb, 8, 1, 2, 1, 768, 3, 6, 29, 1'b1, 1'b1));
            qc.push_back(model(kc, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0));
        end
    end

    // Monitor trackers for the hand-computed boundary checks.
    int   npop = 0;
    int   a_hb_first_h = -1, a_hs_min = 99999, a_hs_max = -1, a_h_max = -1;
    logic a_hb_prev = 1'b0;
    int   b_vb_rise = -1, b_vs_min = 99999, b_vs_max = -1, b_v_max = -1;
    logic b_vb_prev = 1'b0, b_fs_prev = 1'b0;
    int   b_rise[$];
    logic [15:0] c_hs_low = '0;
    logic [7:0]  c_vs_low = '0;
    logic c_fs_prev = 1'b0;
    int   c_rise[$];

    // Monitor: pop and compare each cycle the DUTs present outputs.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
                e = qa.pop_front(); chk_vec("instA", npop, act_a, e);
                e = qb.pop_front(); chk_vec("instB", npop, act_b, e);
                e = qc.pop_front(); chk_vec("instC", npop, act_c, e);

                if (hb_a && !a_hb_prev && a_hb_first_h < 0) a_hb_first_h = int'(h_a);
                a_hb_prev = hb_a;
                if (hs_a) begin
                    if (int'(h_a) < a_hs_min) a_hs_min = int'(h_a);
                    if (int'(h_a) > a_hs_max) a_hs_max = int'(h_a);
                end
                if (int'(h_a) > a_h_max) a_h_max = int'(h_a);

                if (vb_b && !b_vb_prev && b_vb_rise < 0) b_vb_rise = int'(h_b) * 10000 + int'(v_b);
                b_vb_prev = vb_b;
                if (vs_b) begin
                    if (int'(v_b) < b_vs_min) b_vs_min = int'(v_b);
                    if (int'(v_b) > b_vs_max) b_vs_max = int'(v_b);
                end
                if (int'(v_b) > b_v_max) b_v_max = int'(v_b);
                if (fs_b && !b_fs_prev) begin
                    b_rise.push_back(npop);
`ifdef VGA_TIMING_FRAME_CNT_EN
                    chk_int("B_frame_cnt_at_strobe", int'(fc_b), b_rise.size());
`endif
                end
                b_fs_prev = fs_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
                if (npop == 1) chk_int("B_frame_cnt_reset", int'(fc_b), 0);
                if (npop == A_RST_CYC) chk_int("A_frame_cnt_reset", int'(fc_a), 0);
`endif

                if (npop < C_PH1_END) begin
                    if (!hs_c) c_hs_low[h_c[3:0]] = 1'b1;
                    if (!vs_c) c_vs_low[v_c[2:0]] = 1'b1;
                end
                if (fs_c && !c_fs_prev) c_rise.push_back(npop);
                c_fs_prev = fs_c;
                npop++;
            end
        end
    end

    // Final boundary checks with hand-computed values, then the summary.
    initial begin
        int d;
        wait (npop == N_CYC || $time > 64'd10 * (N_CYC + 100));
        #20;
        chk_int("all_vectors_compared", npop, N_CYC);
        chk_int("A_hblnk_first_rise_h", a_hb_first_h, 1024);
        chk_int("A_hsync_first_h", a_hs_min, 1048);
        chk_int("A_hsync_last_h", a_hs_max, 1183);
        chk_int("A_hcount_max", a_h_max, 1343);
        chk_int("B_vblnk_rise_h0_v768", b_vb_rise, 768);
        chk_int("B_vsync_first_v", b_vs_min, 771);
        chk_int("B_vsync_last_v", b_vs_max, 776);
        chk_int("B_vcount_max", b_v_max, 805);
        d = (b_rise.size() >= 2) ? b_rise[1] - b_rise[0] : -1;
        chk_int("B_frame_period", d, 9672);
        chk_int("C_hsync_low_mask", int'(c_hs_low), 32'h0600);
        chk_int("C_vsync_low_mask", int'(c_vs_low), 32'h20);
        d = (c_rise.size() >= 2) ? c_rise[1] - c_rise[0] : -1;
        chk_int("C_frame_period_en1", d, 84);
        d = (c_rise.size() >= 4) ? c_rise[c_rise.size()-1] - c_rise[c_rise.size()-2] : -1;
        chk_int("C_frame_period_en1of3", d, 252);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
